// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, grant source
// encoding and the default memory latency.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;
  typedef enum logic {GNT_IF, GNT_D} gnt_t;
  localparam int MEM_LAT_DEF = 2;
endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Down-counter that times the memory access window; last flags the final
// cycle of the window.
module lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       last
);
  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= 3'd0;
    else if (load)            cnt <= load_val;
    else if (dec && cnt != 0) cnt <= cnt - 3'd1;
  end

  assign last = (cnt == 3'd1);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch and data requesters: grant in IDLE,
// hold the port for MEM_LAT cycles in SERVE, pulse the winner's ready in DONE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [AW-1:0] if_rdata,
  output logic          if_ready,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] d_wdata,
  output logic [AW-1:0] d_rdata,
  output logic          d_ready,
  output logic          d_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic [AW-1:0] mem_rdata
);
  state_t        state, nstate;
  gnt_t          gnt;
  logic          prio_d;
  logic          lat_we;
  logic [AW-1:0] lat_addr, lat_wdata;
  logic          any_req, grant_d, load, last, serve;

  assign any_req = if_req | d_req;
  // Data takes a tie unless it won the previous grant; a lone request always wins.
  assign grant_d = d_req & (~if_req | prio_d);
  assign serve   = (state == SERVE);

  lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (3'(MEM_LAT)),
    .dec      (serve),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    load   = 1'b0;
    case (state)
      IDLE:  if (any_req) begin
               nstate = SERVE;
               load   = 1'b1;
             end
      SERVE: if (last) nstate = DONE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= GNT_IF;
      prio_d    <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt       <= grant_d ? GNT_D : GNT_IF;
        prio_d    <= ~grant_d;
        lat_we    <= grant_d & d_we;
        lat_addr  <= grant_d ? d_addr : if_addr;
        lat_wdata <= grant_d ? d_wdata : '0;
      end
      if (serve && last && !lat_we) begin
        if (gnt == GNT_D) d_rdata  <= mem_rdata;
        else              if_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = serve;
  assign mem_we    = serve & lat_we;
  assign mem_addr  = serve ? lat_addr : '0;
  assign mem_wdata = serve ? lat_wdata : '0;
  assign if_ready  = (state == DONE) && (gnt == GNT_IF);
  assign d_ready   = (state == DONE) && (gnt == GNT_D);
  assign if_stall  = if_req & ~if_ready;
  assign d_stall   = d_req & ~d_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter; a transaction-level model
// (grant time plus phase offset) predicts every output each cycle.
module tb_mem_arbiter;
  localparam int L  = 2;
  localparam int AW = 32;

  logic          clk, rst;
  logic          if_req, if_ready, if_stall;
  logic [AW-1:0] if_addr, if_rdata;
  logic          d_req, d_we, d_ready, d_stall;
  logic [AW-1:0] d_addr, d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tb_mem [256];

  mem_arbiter #(.MEM_LAT(L), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple word memory standing in for the shared port.
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(posedge clk)
    if (mem_en && mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;

  int npass = 0;
  int ntot  = 0;

  // Model: busy with a transaction granted m_p cycles ago.
  bit          m_busy, m_who_d, m_we, m_rr_d, m_just_rst;
  int          m_p;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_d_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic mid();
    bit serving, done_, e_ifr, e_dr;
    @(negedge clk);
    serving = m_busy && m_p >= 1 && m_p <= L;
    done_   = m_busy && m_p == L + 1;
    e_ifr   = done_ && !m_who_d;
    e_dr    = done_ && m_who_d;
    chk("if_ready", {31'b0, if_ready}, {31'b0, e_ifr});
    chk("d_ready",  {31'b0, d_ready},  {31'b0, e_dr});
    chk("if_stall", {31'b0, if_stall}, {31'b0, if_req & ~e_ifr});
    chk("d_stall",  {31'b0, d_stall},  {31'b0, d_req & ~e_dr});
    chk("mem_en",   {31'b0, mem_en},   {31'b0, serving});
    chk("mem_we",   {31'b0, mem_we},   {31'b0, serving & m_we});
    chk("if_rdata", if_rdata, m_if_rd);
    chk("d_rdata",  d_rdata,  m_d_rd);
    chk("ready_excl", {31'b0, if_ready & d_ready}, 32'd0);
    if (serving) begin
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (m_just_rst) begin
      chk("rst_mem_addr",  mem_addr,  32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
    end
  endtask

  task automatic edge_();
    bit pick_d;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_p = 0; m_rr_d = 1; m_just_rst = 1;
      m_if_rd = '0; m_d_rd = '0; m_we = 0;
    end else begin
      m_just_rst = 0;
      if (m_busy) begin
        if (m_p == L && !m_we) begin
          if (m_who_d) m_d_rd  = tb_mem[m_addr[9:2]];
          else         m_if_rd = tb_mem[m_addr[9:2]];
        end
        if (m_p == L + 1) m_busy = 0;
        else              m_p++;
      end else if (if_req || d_req) begin
        pick_d  = d_req && (!if_req || m_rr_d);
        m_who_d = pick_d;
        m_rr_d  = !pick_d;
        m_we    = pick_d && d_we;
        m_addr  = pick_d ? d_addr : if_addr;
        m_wdata = d_wdata;
        m_busy  = 1; m_p = 1;
      end
    end
    #1;
  endtask

  task automatic cycle();
    mid();
    edge_();
  endtask

  task automatic idle_inputs();
    if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    byte         ord[$];
    byte         exp_ord[4];
    logic [31:0] saved;
    for (int i = 0; i < 256; i++) tb_mem[i] = $urandom;
    tb_mem[16] = 32'h2002000A;
    exp_ord[0] = "D"; exp_ord[1] = "I"; exp_ord[2] = "D"; exp_ord[3] = "I";
    m_busy = 0; m_p = 0; m_rr_d = 1; m_just_rst = 1; m_we = 0;
    m_who_d = 0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_d_rd = '0;

    // Reset for two cycles, then quiet.
    rst = 1; idle_inputs();
    edge_();
    cycle();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("quiet_mem_en", {31'b0, mem_en}, 32'd0); edge_();
    end

    // Single fetch from 0x40.
    if_req = 1; if_addr = 32'h40;
    mid(); chk("f_stall0", {31'b0, if_stall}, 32'd1); edge_();
    for (int c = 1; c <= 2; c++) begin
      mid();
      chk("f_mem_en", {31'b0, mem_en}, 32'd1);
      chk("f_mem_addr", mem_addr, 32'h40);
      chk("f_stall", {31'b0, if_stall}, 32'd1);
      edge_();
    end
    mid();
    chk("f_ready3", {31'b0, if_ready}, 32'd1);
    chk("f_rdata3", if_rdata, 32'h2002000A);
    edge_();
    idle_inputs(); cycle();

    // Collision after reset: data first, then fetch.
    rst = 1; cycle(); rst = 0;
    if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h100;
    for (int c = 0; c < 3; c++) cycle();
    mid(); chk("col_d_ready3", {31'b0, d_ready}, 32'd1); edge_();
    d_req = 0;
    mid(); chk("col_en4", {31'b0, mem_en}, 32'd0); edge_();
    for (int c = 5; c <= 6; c++) begin
      mid(); chk("col_mem_addr", mem_addr, 32'h44); edge_();
    end
    mid(); chk("col_if_ready7", {31'b0, if_ready}, 32'd1); edge_();
    idle_inputs(); cycle();

    // Both held for 16 cycles: grants alternate starting with data.
    if_req = 1; if_addr = 32'h80; d_req = 1; d_addr = 32'h200;
    for (int c = 0; c < 16; c++) begin
      mid();
      if (d_ready)  ord.push_back("D");
      if (if_ready) ord.push_back("I");
      edge_();
    end
    chk("rr_count", ord.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < ord.size()) ? {24'b0, ord[i]} : 32'd0, {24'b0, exp_ord[i]});
    idle_inputs(); cycle();

    // Data write.
    saved = m_d_rd;
    d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
    cycle();
    for (int c = 1; c <= 2; c++) begin
      mid();
      chk("w_mem_we", {31'b0, mem_we}, 32'd1);
      chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
      edge_();
    end
    mid();
    chk("w_d_ready3", {31'b0, d_ready}, 32'd1);
    chk("w_rdata_hold", d_rdata, saved);
    edge_();
    idle_inputs(); cycle();

    // Reset during a fetch aborts it; a fresh fetch then completes normally.
    if_req = 1; if_addr = 32'h40;
    cycle(); cycle();
    rst = 1; cycle();
    rst = 0; if_req = 0;
    mid();
    chk("ab_mem_en3", {31'b0, mem_en}, 32'd0);
    chk("ab_if_ready3", {31'b0, if_ready}, 32'd0);
    chk("ab_if_rdata3", if_rdata, 32'd0);
    chk("ab_mem_addr3", mem_addr, 32'd0);
    edge_();
    if_req = 1; if_addr = 32'h40;
    for (int c = 4; c < 7; c++) cycle();
    mid();
    chk("ab_if_ready7", {31'b0, if_ready}, 32'd1);
    chk("ab_if_rdata7", if_rdata, 32'h2002000A);
    edge_();
    idle_inputs(); cycle();

    // Randomized traffic, including occasional resets and dropped requests.
    for (int c = 0; c < 500; c++) begin
      rst     = ($urandom_range(0, 39) == 0);
      if_req  = ($urandom_range(0, 2) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1);
      if_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      d_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      d_wdata = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
